// File: rtl/cell_pos_streamer.sv
// Reads one cell's particle count, then streams every particle position word out of the cell memory.
// Latency: first word valid 7 cycles after start; with the consumer always ready, one word per cycle, done at count+8.
// Backpressure: reads are issued only against free skid-FIFO credit, and the FIFO head holds steady while stalled.
module cell_pos_streamer #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_rden,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic [DATA_WIDTH-1:0] pos_data,
   output logic [ADDR_WIDTH-1:0] pos_id,
   output logic                  pos_last,
   output logic                  pos_valid,
   input  logic                  pos_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  count_err
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] MAX_ID   = ADDR_WIDTH'(PARTICLE_NUM - 1);
   localparam logic [PW-1:0]         PTR_LAST = PW'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CNT_RD, S_CNT_WAIT, S_STREAM, S_DRAIN, S_FINISH
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic [ADDR_WIDTH-1:0] r_count;
   logic                  r_mem_rden;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_count_err;
   logic                  r_wait;
   logic                  r_last_xfer;

   // Issue tags: stage 0 rides alongside the read-enable register, stages 1-2 track the memory latency
   logic                  r_t0_vld, r_t0_last;
   logic                  r_t1_vld, r_t1_last;
   logic                  r_t2_vld, r_t2_last;
   logic [ADDR_WIDTH-1:0] r_t1_addr, r_t2_addr;

   logic [DATA_WIDTH-1:0] r_fifo_dat [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_fifo_id  [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_fifo_last;
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_fifo_cnt;

   logic                  w_push;
   logic                  w_pop;
   logic [1:0]            w_inflight;
   logic                  w_credit;
   logic [ADDR_WIDTH-1:0] w_cnt_raw;
   logic                  w_cnt_over;
   logic [ADDR_WIDTH-1:0] w_cnt;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_push     = r_t2_vld;
   assign w_pop      = pos_valid && pos_ready;
   assign w_inflight = {1'b0, r_t0_vld} + {1'b0, r_t1_vld} + {1'b0, r_t2_vld};
   // A word leaving the FIFO this cycle frees its slot for the read issued at this edge,
   // which is what lets the stream sustain one word per cycle with a 4-deep FIFO.
   assign w_credit   = (int'(r_fifo_cnt) + int'(w_inflight)) < (FIFO_DEPTH + int'(w_pop));

   assign w_cnt_raw  = mem_q[ADDR_WIDTH-1:0];
   assign w_cnt_over = (w_cnt_raw > MAX_ID);
   assign w_cnt      = w_cnt_over ? MAX_ID : w_cnt_raw;

   assign mem_address = r_mem_address;
   assign mem_rden    = r_mem_rden;
   assign mem_wren    = 1'b0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign count_err   = r_count_err;
   assign pos_valid   = (r_fifo_cnt != '0);
   assign pos_data    = r_fifo_dat[r_rd_ptr];
   assign pos_id      = r_fifo_id[r_rd_ptr];
   assign pos_last    = pos_valid && r_fifo_last[r_rd_ptr];

   // Sequencer: count read, credit-gated particle reads, drain, completion pulse
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_mem_address <= '0;
         r_mem_rden    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_count_err   <= 1'b0;
         r_count       <= '0;
         r_next_addr   <= '0;
         r_wait        <= 1'b0;
         r_last_xfer   <= 1'b0;
         r_t0_vld      <= 1'b0;
         r_t0_last     <= 1'b0;
      end else begin
         r_mem_rden <= 1'b0;
         r_done     <= 1'b0;
         r_t0_vld   <= 1'b0;
         r_t0_last  <= 1'b0;
         if (w_pop && pos_last) r_last_xfer <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state       <= S_CNT_RD;
                  r_busy        <= 1'b1;
                  r_count_err   <= 1'b0;
                  r_last_xfer   <= 1'b0;
                  r_mem_address <= '0;
                  r_mem_rden    <= 1'b1;
               end
            end
            S_CNT_RD: begin
               r_state <= S_CNT_WAIT;
               r_wait  <= 1'b0;
            end
            S_CNT_WAIT: begin
               if (!r_wait) begin
                  r_wait <= 1'b1;
               end else begin
                  r_count     <= w_cnt;
                  r_count_err <= w_cnt_over;
                  if (w_cnt == '0) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     // The FIFO is empty here, so the first particle read goes out with the count
                     r_mem_address <= ADDR_WIDTH'(1);
                     r_mem_rden    <= 1'b1;
                     r_t0_vld      <= 1'b1;
                     r_t0_last     <= (w_cnt == ADDR_WIDTH'(1));
                     r_next_addr   <= ADDR_WIDTH'(2);
                     r_state       <= (w_cnt == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
                  end
               end
            end
            S_STREAM: begin
               if (w_credit) begin
                  r_mem_address <= r_next_addr;
                  r_mem_rden    <= 1'b1;
                  r_t0_vld      <= 1'b1;
                  r_t0_last     <= (r_next_addr == r_count);
                  r_next_addr   <= r_next_addr + 1'b1;
                  if (r_next_addr == r_count) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_inflight == 2'd0 && r_fifo_cnt == '0 && r_last_xfer) begin
                  r_state <= S_FINISH;
                  r_done  <= 1'b1;
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Tag pipeline matching the two-cycle memory latency
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_t1_vld  <= 1'b0;
         r_t1_last <= 1'b0;
         r_t1_addr <= '0;
         r_t2_vld  <= 1'b0;
         r_t2_last <= 1'b0;
         r_t2_addr <= '0;
      end else begin
         r_t1_vld  <= r_t0_vld;
         r_t1_last <= r_t0_last;
         r_t1_addr <= r_mem_address;
         r_t2_vld  <= r_t1_vld;
         r_t2_last <= r_t1_last;
         r_t2_addr <= r_t1_addr;
      end
   end

   // Output skid FIFO: returning words with their tags, head drives the stream
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_dat[i] <= '0;
            r_fifo_id[i]  <= '0;
         end
         r_fifo_last <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_fifo_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_fifo_dat[r_wr_ptr]  <= mem_q;
            r_fifo_id[r_wr_ptr]   <= r_t2_addr;
            r_fifo_last[r_wr_ptr] <= r_t2_last;
            r_wr_ptr              <= f_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

endmodule
